// File: rtl/ramctl_pkg.sv
// Shared constants and helpers for the fast RAM sequencer.
package ramctl_pkg;

  // Default timing, in CLKCPU cycles
  localparam int unsigned DEF_REFRESH_INTERVAL = 220;
  localparam int unsigned DEF_PRECHARGE_CYCLES = 2;
  localparam int unsigned DEF_REF_RAS_CYCLES   = 2;

  // Sequencer states
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ROW   = 3'd1;
  localparam logic [2:0] COL   = 3'd2;
  localparam logic [2:0] ACK   = 3'd3;
  localparam logic [2:0] PRE   = 3'd4;
  localparam logic [2:0] RCAS  = 3'd5;
  localparam logic [2:0] RRAS  = 3'd6;
  localparam logic [2:0] RHOLD = 3'd7;

  // Active-low CAS lane mask. Reads enable every lane; writes enable byte
  // offsets a_lo..min(3, a_lo+n-1), offset k mapping to CAS[3-k].
  function automatic logic [3:0] cas_lanes(input logic [1:0] siz, input logic [1:0] a_lo,
                                           input logic rw);
    logic [3:0] m;
    int         n;
    m = 4'b1111;
    if (rw) begin
      m = 4'b0000;
    end else begin
      n = (siz == 2'b00) ? 4 : int'(siz);
      for (int k = 0; k < 4; k++) begin
        if (k >= int'(a_lo) && k < int'(a_lo) + n) m[2'(3 - k)] = 1'b0;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/refresh_timer.sv
// Refresh interval timer with a saturating count of outstanding refreshes.
module refresh_timer
  import ramctl_pkg::*;
#(
  parameter int unsigned REFRESH_INTERVAL = DEF_REFRESH_INTERVAL
) (
  input  logic CLKCPU,
  input  logic RESET,
  input  logic tick_dec,
  output logic pending_nz
);

  localparam int unsigned TW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam logic [TW-1:0] RELOAD = TW'(REFRESH_INTERVAL - 1);

  logic [TW-1:0] tmr_q;
  logic [1:0]    pend_q, pend_d;
  logic          expire;

  assign expire     = (tmr_q == '0);
  assign pending_nz = (pend_q != 2'd0);

  // Saturating pending count; simultaneous expiry and service cancel out
  always_comb begin
    pend_d = pend_q;
    if (expire && !tick_dec && pend_q != 2'd3) begin
      pend_d = pend_q + 2'd1;
    end else if (tick_dec && !expire && pend_q != 2'd0) begin
      pend_d = pend_q - 2'd1;
    end
  end

  // Down-counter and pending count state
  always_ff @(posedge CLKCPU) begin
    if (!RESET) begin
      tmr_q  <= RELOAD;
      pend_q <= 2'd0;
    end else begin
      tmr_q  <= expire ? RELOAD : tmr_q - TW'(1);
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/fastram_sequencer.sv
// Fast RAM DRAM cycle sequencer: arbitrates refresh against CPU accesses and
// drives registered RAS/CAS/mux/OE/ready strobes.
module fastram_sequencer
  import ramctl_pkg::*;
#(
  parameter int unsigned REFRESH_INTERVAL = DEF_REFRESH_INTERVAL,
  parameter int unsigned PRECHARGE_CYCLES = DEF_PRECHARGE_CYCLES,
  parameter int unsigned REF_RAS_CYCLES   = DEF_REF_RAS_CYCLES
) (
  input  logic       CLKCPU,
  input  logic       RESET,
  input  logic       AS20,
  input  logic       RW20,
  input  logic [1:0] SIZ,
  input  logic [1:0] A_LO,
  input  logic       RAM_SEL,
  input  logic       BANK,
  output logic [1:0] RAS,
  output logic [3:0] CAS,
  output logic       RAM_MUX,
  output logic       RAMOE,
  output logic       RAM_READY,
  output logic       REF_BUSY
);

  localparam logic [7:0] PRE_LOAD = 8'(PRECHARGE_CYCLES - 1);
  localparam logic [7:0] RAS_LOAD = 8'(REF_RAS_CYCLES - 1);

  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       ref_q, ref_d;
  logic       bank_q, bank_d, rw_q, rw_d;
  logic [1:0] siz_q, siz_d, alo_q, alo_d;
  logic       pending_nz, tick_dec;

  logic [1:0] ras_d;
  logic [3:0] cas_d;
  logic       mux_d, oe_d, rdy_d, busy_d;

  // Pending count is serviced as the refresh leaves RCAS for RRAS
  assign tick_dec = (state_q == RCAS);

  refresh_timer #(
    .REFRESH_INTERVAL(REFRESH_INTERVAL)
  ) u_refresh_timer (
    .CLKCPU    (CLKCPU),
    .RESET     (RESET),
    .tick_dec  (tick_dec),
    .pending_nz(pending_nz)
  );

  // Next-state: refresh wins over the CPU at IDLE; shared counter times PRE and RAS hold
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ref_d   = ref_q;
    bank_d  = bank_q;
    rw_d    = rw_q;
    siz_d   = siz_q;
    alo_d   = alo_q;
    case (state_q)
      IDLE: begin
        if (pending_nz) begin
          state_d = RCAS;
          ref_d   = 1'b1;
        end else if (!AS20 && RAM_SEL) begin
          state_d = ROW;
          bank_d  = BANK;
          rw_d    = RW20;
          siz_d   = SIZ;
          alo_d   = A_LO;
        end
      end
      ROW, COL, ACK: begin
        if (AS20) begin
          state_d = PRE;
          cnt_d   = PRE_LOAD;
        end else if (state_q == ROW) begin
          state_d = COL;
        end else begin
          state_d = ACK;
        end
      end
      PRE: begin
        if (cnt_q == 8'd0) begin
          state_d = IDLE;
          ref_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RCAS: begin
        state_d = RRAS;
        cnt_d   = RAS_LOAD;
      end
      RRAS, RHOLD: begin
        if (cnt_q == 8'd0) begin
          state_d = PRE;
          cnt_d   = PRE_LOAD;
        end else begin
          state_d = RHOLD;
          cnt_d   = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the current state, registered below
  always_comb begin
    ras_d  = 2'b11;
    cas_d  = 4'b1111;
    mux_d  = 1'b0;
    oe_d   = 1'b1;
    rdy_d  = 1'b1;
    busy_d = 1'b0;
    case (state_q)
      ROW: ras_d[bank_q] = 1'b0;
      COL, ACK: begin
        ras_d[bank_q] = 1'b0;
        mux_d         = 1'b1;
        cas_d         = cas_lanes(siz_q, alo_q, rw_q);
        oe_d          = ~rw_q;
        rdy_d         = (state_q != ACK);
      end
      PRE:  busy_d = ref_q;
      RCAS: begin
        cas_d  = 4'b0000;
        busy_d = 1'b1;
      end
      RRAS, RHOLD: begin
        ras_d  = 2'b00;
        cas_d  = 4'b0000;
        busy_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Sequencer state and registered DRAM control outputs
  always_ff @(posedge CLKCPU) begin
    if (!RESET) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      ref_q     <= 1'b0;
      bank_q    <= 1'b0;
      rw_q      <= 1'b1;
      siz_q     <= 2'b00;
      alo_q     <= 2'b00;
      RAS       <= 2'b11;
      CAS       <= 4'b1111;
      RAM_MUX   <= 1'b0;
      RAMOE     <= 1'b1;
      RAM_READY <= 1'b1;
      REF_BUSY  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ref_q     <= ref_d;
      bank_q    <= bank_d;
      rw_q      <= rw_d;
      siz_q     <= siz_d;
      alo_q     <= alo_d;
      RAS       <= ras_d;
      CAS       <= cas_d;
      RAM_MUX   <= mux_d;
      RAMOE     <= oe_d;
      RAM_READY <= rdy_d;
      REF_BUSY  <= busy_d;
    end
  end

endmodule

// File: tb/tb_fastram_sequencer.sv
// Directed bench for fastram_sequencer: CPU cycle vector table plus refresh corner cases.
module tb_fastram_sequencer;

  logic       CLKCPU = 1'b0;
  logic       RESET  = 1'b0;
  logic       AS20   = 1'b1;
  logic       RW20   = 1'b1;
  logic [1:0] SIZ    = 2'b00;
  logic [1:0] A_LO   = 2'b00;
  logic       RAM_SEL = 1'b0;
  logic       BANK   = 1'b0;
  logic [1:0] RAS;
  logic [3:0] CAS;
  logic       RAM_MUX, RAMOE, RAM_READY, REF_BUSY;

  int total = 0;
  int bad   = 0;

  fastram_sequencer dut (
    .CLKCPU   (CLKCPU),
    .RESET    (RESET),
    .AS20     (AS20),
    .RW20     (RW20),
    .SIZ      (SIZ),
    .A_LO     (A_LO),
    .RAM_SEL  (RAM_SEL),
    .BANK     (BANK),
    .RAS      (RAS),
    .CAS      (CAS),
    .RAM_MUX  (RAM_MUX),
    .RAMOE    (RAMOE),
    .RAM_READY(RAM_READY),
    .REF_BUSY (REF_BUSY)
  );

  always #5 CLKCPU = ~CLKCPU;

  typedef struct {
    logic       rw;
    logic [1:0] siz;
    logic [1:0] a_lo;
    logic       bank;
    logic [1:0] ras;
    logic [3:0] cas;
    logic       oe;
  } vec_t;

  vec_t vecs[9];

  // Packed view {RAS, CAS, RAM_MUX, RAMOE, RAM_READY, REF_BUSY}
  function automatic logic [9:0] pk(input logic [1:0] r, input logic [3:0] c, input logic m,
                                    input logic o, input logic rdy, input logic b);
    return {r, c, m, o, rdy, b};
  endfunction

  function automatic logic [9:0] outs();
    return {RAS, CAS, RAM_MUX, RAMOE, RAM_READY, REF_BUSY};
  endfunction

  task automatic tick();
    @(posedge CLKCPU);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic do_reset();
    AS20    = 1'b1;
    RAM_SEL = 1'b0;
    RESET   = 1'b0;
    tick();
    RESET = 1'b1;
  endtask

  localparam logic [9:0] IDLE_OUT = 10'b11_1111_0_1_1_0;

  int busy_cnt, rises;
  logic prev_busy;

  initial begin
    vecs[0] = '{1'b1, 2'b00, 2'b00, 1'b1, 2'b01, 4'b0000, 1'b0};
    vecs[1] = '{1'b1, 2'b01, 2'b11, 1'b0, 2'b10, 4'b0000, 1'b0};
    vecs[2] = '{1'b0, 2'b01, 2'b10, 1'b0, 2'b10, 4'b1101, 1'b1};
    vecs[3] = '{1'b0, 2'b10, 2'b11, 1'b1, 2'b01, 4'b1110, 1'b1};
    vecs[4] = '{1'b0, 2'b00, 2'b00, 1'b0, 2'b10, 4'b0000, 1'b1};
    vecs[5] = '{1'b0, 2'b10, 2'b00, 1'b1, 2'b01, 4'b0011, 1'b1};
    vecs[6] = '{1'b0, 2'b11, 2'b01, 1'b0, 2'b10, 4'b1000, 1'b1};
    vecs[7] = '{1'b0, 2'b01, 2'b00, 1'b1, 2'b01, 4'b0111, 1'b1};
    vecs[8] = '{1'b0, 2'b00, 2'b10, 1'b0, 2'b10, 4'b1100, 1'b1};

    do_reset();
    check("reset_values", 16'(outs()), 16'(IDLE_OUT));

    // CPU cycles from the table, each starting just after a reset
    for (int i = 0; i < 9; i++) begin
      do_reset();
      RW20 = vecs[i].rw; SIZ = vecs[i].siz; A_LO = vecs[i].a_lo; BANK = vecs[i].bank;
      AS20 = 1'b0; RAM_SEL = 1'b1;
      tick();  // edge 0: request sampled
      tick();
      check($sformatf("v%0d_row", i), 16'(outs()), 16'(pk(vecs[i].ras, 4'hF, 0, 1, 1, 0)));
      tick();
      check($sformatf("v%0d_col", i), 16'(outs()),
            16'(pk(vecs[i].ras, vecs[i].cas, 1, vecs[i].oe, 1, 0)));
      tick();
      check($sformatf("v%0d_ack", i), 16'(outs()),
            16'(pk(vecs[i].ras, vecs[i].cas, 1, vecs[i].oe, 0, 0)));
      AS20 = 1'b1; RAM_SEL = 1'b0;
      tick();  // AS20 high sampled here
      check($sformatf("v%0d_ack_hold", i), 16'(RAM_READY), 16'(0));
      tick();
      check($sformatf("v%0d_release", i), 16'(outs()), 16'(IDLE_OUT));
    end

    // Abort in COL: ready never asserted, precharge next edge
    do_reset();
    RW20 = 1'b0; SIZ = 2'b00; A_LO = 2'b00; BANK = 1'b0;
    AS20 = 1'b0; RAM_SEL = 1'b1;
    tick();
    tick();
    AS20 = 1'b1; RAM_SEL = 1'b0;
    tick();
    check("abort_col_out", 16'(outs()), 16'(pk(2'b10, 4'b0000, 1, 1, 1, 0)));
    tick();
    check("abort_pre", 16'(outs()), 16'(IDLE_OUT));
    tick();
    check("abort_no_ready", 16'(RAM_READY), 16'(1));

    // Refresh and CPU request meet in the same IDLE cycle
    do_reset();
    repeat (220) tick();
    RW20 = 1'b1; SIZ = 2'b00; A_LO = 2'b00; BANK = 1'b0;
    AS20 = 1'b0; RAM_SEL = 1'b1;
    tick();
    check("pri_idle", 16'(outs()), 16'(IDLE_OUT));
    tick();
    check("pri_rcas", 16'(outs()), 16'(pk(2'b11, 4'b0000, 0, 1, 1, 1)));
    tick();
    check("pri_rras1", 16'(outs()), 16'(pk(2'b00, 4'b0000, 0, 1, 1, 1)));
    tick();
    check("pri_rras2", 16'(outs()), 16'(pk(2'b00, 4'b0000, 0, 1, 1, 1)));
    tick();
    check("pri_pre1", 16'(outs()), 16'(pk(2'b11, 4'b1111, 0, 1, 1, 1)));
    tick();
    check("pri_pre2", 16'(outs()), 16'(pk(2'b11, 4'b1111, 0, 1, 1, 1)));
    tick();
    check("pri_idle2", 16'(outs()), 16'(IDLE_OUT));
    tick();
    check("pri_cpu_row", 16'(outs()), 16'(pk(2'b10, 4'b1111, 0, 1, 1, 0)));
    tick();
    check("pri_cpu_col", 16'(outs()), 16'(pk(2'b10, 4'b0000, 1, 0, 1, 0)));
    tick();
    check("pri_cpu_ack", 16'(outs()), 16'(pk(2'b10, 4'b0000, 1, 0, 0, 0)));
    AS20 = 1'b1; RAM_SEL = 1'b0;
    repeat (2) tick();
    check("pri_cpu_done", 16'(outs()), 16'(IDLE_OUT));

    // Stall across four intervals: pending saturates at three
    do_reset();
    RW20 = 1'b1; BANK = 1'b1;
    AS20 = 1'b0; RAM_SEL = 1'b1;
    busy_cnt = 0;
    for (int c = 0; c < 900; c++) begin
      tick();
      if (REF_BUSY) busy_cnt++;
    end
    check("stall_no_refresh", 16'(busy_cnt), 16'(0));
    check("stall_ready", 16'(RAM_READY), 16'(0));
    AS20 = 1'b1; RAM_SEL = 1'b0;
    busy_cnt  = 0;
    rises     = 0;
    prev_busy = 1'b0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (REF_BUSY) busy_cnt++;
      if (REF_BUSY && !prev_busy) rises++;
      if (REF_BUSY && !RAM_READY) check("stall_ready_in_ref", 16'(RAM_READY), 16'(1));
      prev_busy = REF_BUSY;
    end
    check("stall_refresh_count", 16'(rises), 16'(3));
    check("stall_busy_cycles", 16'(busy_cnt), 16'(15));

    // Reset in the middle of a refresh RAS phase
    do_reset();
    repeat (223) tick();
    check("mid_rras", 16'(outs()), 16'(pk(2'b00, 4'b0000, 0, 1, 1, 1)));
    RESET = 1'b0;
    tick();
    check("mid_reset_out", 16'(outs()), 16'(IDLE_OUT));
    RESET    = 1'b1;
    busy_cnt = 0;
    for (int c = 0; c < 221; c++) begin
      tick();
      if (REF_BUSY) busy_cnt++;
    end
    check("post_reset_quiet", 16'(busy_cnt), 16'(0));
    tick();
    check("post_reset_refresh", 16'(outs()), 16'(pk(2'b11, 4'b0000, 0, 1, 1, 1)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
